qaoa_kernel_udiv_76ns_46ns_32_seq: RTL and testbench

//  Iterative unsigned restoring divider: dout = din0 / din1, rem = din0 % din1.

---
 rtl/qaoa_kernel_udiv_76ns_46ns_32_seq_if.sv | 29 ++
 rtl/qaoa_kernel_udiv_76ns_46ns_32_seq.sv | 146 ++++++++++++++
 tb/tb_qaoa_kernel_udiv_76ns_46ns_32_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qaoa_kernel_udiv_76ns_46ns_32_seq_if.sv
// Operand/result handshake bundle for the sequential 76/46 unsigned divider.
// ce travels with the bus because it gates every handshake on both sides.
interface qaoa_kernel_udiv_76ns_46ns_32_seq_if #(
    parameter int din0_WIDTH = 76,
    parameter int din1_WIDTH = 46,
    parameter int dout_WIDTH = 32
);
    logic                  ce;
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH-1:0] rem;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output ce, in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, rem, div_by_zero, overflow
    );

    modport slave (
        input  ce, in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, rem, div_by_zero, overflow
    );
endinterface

// File: rtl/qaoa_kernel_udiv_76ns_46ns_32_seq.sv
// Iterative unsigned restoring divider, one quotient bit per enabled cycle.
// Recovers 32-bit scaled terms from 76-bit fixed-point products.
module qaoa_kernel_udiv_76ns_46ns_32_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 76,
    parameter int din1_WIDTH = 46,
    parameter int dout_WIDTH = 32
) (
    input  logic clk,
    input  logic reset_n,
    qaoa_kernel_udiv_76ns_46ns_32_seq_if.slave bus
);
    localparam int CNT_W  = (dout_WIDTH > 1) ? $clog2(dout_WIDTH) : 1;
    localparam int WIDE_W = din0_WIDTH + din1_WIDTH;

    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

    // A dividend wider than quotient+divisor could hide quotient bits the loop never produces.
    if (ID < 0 || din0_WIDTH > dout_WIDTH + din1_WIDTH) begin : g_paramCheck
        $error("qaoa_kernel_udiv: invalid parameter set");
    end

    state_t                r_state,    w_stateNext;
    logic [din0_WIDTH-1:0] r_dividend, w_dividendNext;
    logic [din1_WIDTH-1:0] r_divisor,  w_divisorNext;
    logic [din1_WIDTH-1:0] r_partial,  w_partialNext;
    logic [dout_WIDTH-1:0] r_quot,     w_quotNext;
    logic [CNT_W-1:0]      r_cnt,      w_cntNext;
    logic [dout_WIDTH-1:0] r_dout,     w_doutNext;
    logic [din1_WIDTH-1:0] r_rem,      w_remNext;
    logic                  r_dbz,      w_dbzNext;
    logic                  r_ovf,      w_ovfNext;

    logic [dout_WIDTH-1:0] w_lowBits;
    logic [din1_WIDTH:0]   w_trial;
    logic                  w_fits;
    logic [din1_WIDTH-1:0] w_partialStep;
    logic [dout_WIDTH-1:0] w_quotStep;
    logic                  w_tooBig;

    // The partial remainder stays below the divisor, so one extra bit holds the shifted trial value.
    assign w_lowBits     = r_dividend[dout_WIDTH-1:0];
    assign w_trial       = {r_partial, w_lowBits[r_cnt]};
    assign w_fits        = (w_trial >= {1'b0, r_divisor});
    assign w_partialStep = w_fits ? din1_WIDTH'(w_trial - {1'b0, r_divisor})
                                  : w_trial[din1_WIDTH-1:0];
    assign w_tooBig      = (WIDE_W'(r_dividend) >> dout_WIDTH) >= WIDE_W'(r_divisor);

    always_comb begin
        w_quotStep        = r_quot;
        w_quotStep[r_cnt] = w_fits;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_partial  <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (bus.ce) begin
            r_state    <= w_stateNext;
            r_dividend <= w_dividendNext;
            r_divisor  <= w_divisorNext;
            r_partial  <= w_partialNext;
            r_quot     <= w_quotNext;
            r_cnt      <= w_cntNext;
            r_dout     <= w_doutNext;
            r_rem      <= w_remNext;
            r_dbz      <= w_dbzNext;
            r_ovf      <= w_ovfNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_dividendNext = r_dividend;
        w_divisorNext  = r_divisor;
        w_partialNext  = r_partial;
        w_quotNext     = r_quot;
        w_cntNext      = r_cnt;
        w_doutNext     = r_dout;
        w_remNext      = r_rem;
        w_dbzNext      = r_dbz;
        w_ovfNext      = r_ovf;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_dividendNext = bus.din0;
                    w_divisorNext  = bus.din1;
                    w_stateNext    = CHECK;
                end
            end
            CHECK: begin
                if (r_divisor == '0) begin
                    w_doutNext  = '1;
                    w_remNext   = r_dividend[din1_WIDTH-1:0];
                    w_dbzNext   = 1'b1;
                    w_ovfNext   = 1'b0;
                    w_stateNext = DONE;
                end else if (w_tooBig) begin
                    w_doutNext  = '1;
                    w_remNext   = '0;
                    w_dbzNext   = 1'b0;
                    w_ovfNext   = 1'b1;
                    w_stateNext = DONE;
                end else begin
                    w_partialNext = din1_WIDTH'(r_dividend >> dout_WIDTH);
                    w_cntNext     = CNT_W'(dout_WIDTH - 1);
                    w_stateNext   = ITER;
                end
            end
            ITER: begin
                w_partialNext = w_partialStep;
                w_quotNext    = w_quotStep;
                if (r_cnt == '0) begin
                    w_doutNext  = w_quotStep;
                    w_remNext   = w_partialStep;
                    w_dbzNext   = 1'b0;
                    w_ovfNext   = 1'b0;
                    w_stateNext = DONE;
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.dout        = r_dout;
    assign bus.rem         = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_qaoa_kernel_udiv_76ns_46ns_32_seq.sv
// Self-checking bench for the sequential divider: fixed vectors, stall/reset
// sequences and randomized operands against a plain-arithmetic model.
module tb_qaoa_kernel_udiv_76ns_46ns_32_seq;
    localparam int W0          = 76;
    localparam int W1          = 46;
    localparam int WQ          = 32;
    localparam int NORMAL_LAT  = WQ + 2;
    localparam int SPECIAL_LAT = 2;
    localparam int WAIT_LIMIT  = 200;
    localparam int NUM_VECS    = 11;
    localparam int NUM_RANDOM  = 1000;

    typedef struct {
        logic [W0-1:0] din0;
        logic [W1-1:0] din1;
        logic [WQ-1:0] expDout;
        logic [W1-1:0] expRem;
        logic          expDbz;
        logic          expOvf;
        int            expLat;
    } vector_t;

    logic clk = 1'b0;
    logic reset_n;
    int   vectorCount = 0;
    int   missCount   = 0;
    int   cycleCount  = 0;
    int   acceptCycle = 0;

    qaoa_kernel_udiv_76ns_46ns_32_seq_if #(
        .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WQ)
    ) bus ();

    qaoa_kernel_udiv_76ns_46ns_32_seq #(
        .ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WQ)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference: full-width quotient, then classify; independent of the bit-serial loop.
    function automatic void modelDivide(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                        output logic [WQ-1:0] q, output logic [W1-1:0] r,
                                        output logic dbz, output logic ovf, output int lat);
        logic [W0-1:0] fullQ;
        logic [W0-1:0] fullR;
        dbz = 1'b0;
        ovf = 1'b0;
        lat = NORMAL_LAT;
        if (b == '0) begin
            q   = '1;
            r   = a[W1-1:0];
            dbz = 1'b1;
            lat = SPECIAL_LAT;
        end else begin
            fullQ = a / W0'(b);
            fullR = a % W0'(b);
            if (fullQ >= (W0'(1) << WQ)) begin
                q   = '1;
                r   = '0;
                ovf = 1'b1;
                lat = SPECIAL_LAT;
            end else begin
                q = fullQ[WQ-1:0];
                r = fullR[W1-1:0];
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W0-1:0] a, input logic [W1-1:0] b);
        int guard = 0;
        while (!bus.in_ready && guard < WAIT_LIMIT) begin
            step();
            guard++;
        end
        checkOutput("in_ready before accept", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        step();
        acceptCycle  = cycleCount - 1;
        bus.in_valid = 1'b0;
        bus.din0     = W0'({$urandom(), $urandom(), $urandom()});
        bus.din1     = W1'({$urandom(), $urandom()});
    endtask

    task automatic waitResult(output int lat);
        int guard = 0;
        while (!bus.out_valid && guard < WAIT_LIMIT) begin
            step();
            guard++;
        end
        lat = bus.out_valid ? (cycleCount - acceptCycle) : -1;
    endtask

    task automatic checkResult(input string tag, input logic [WQ-1:0] q, input logic [W1-1:0] r,
                               input logic dbz, input logic ovf);
        checkOutput($sformatf("%s dout", tag), 128'(bus.dout), 128'(q));
        checkOutput($sformatf("%s rem", tag), 128'(bus.rem), 128'(r));
        checkOutput($sformatf("%s div_by_zero", tag), 128'(bus.div_by_zero), 128'(dbz));
        checkOutput($sformatf("%s overflow", tag), 128'(bus.overflow), 128'(ovf));
    endtask

    task automatic releaseResult(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checkOutput($sformatf("%s out_valid drop", tag), 128'(bus.out_valid), 128'(0));
    endtask

    task automatic runVector(input string tag, input vector_t v);
        int lat;
        applyStimulus(v.din0, v.din1);
        waitResult(lat);
        checkOutput($sformatf("%s latency", tag), 128'(lat), 128'(v.expLat));
        checkResult(tag, v.expDout, v.expRem, v.expDbz, v.expOvf);
        releaseResult(tag);
    endtask

    initial begin
        vector_t vecs [NUM_VECS];
        vector_t v;
        int      lat;
        int      mode;
        int      hold;
        logic [WQ-1:0] a;

        vecs[0]  = '{76'd1000, 46'd7, 32'd142, 46'd6, 1'b0, 1'b0, NORMAL_LAT};
        vecs[1]  = '{76'd123, 46'd0, 32'hFFFF_FFFF, 46'd123, 1'b1, 1'b0, SPECIAL_LAT};
        vecs[2]  = '{76'h5_0000_0000, 46'd5, 32'hFFFF_FFFF, 46'd0, 1'b0, 1'b1, SPECIAL_LAT};
        vecs[3]  = '{76'h4_FFFF_FFFF, 46'd5, 32'hFFFF_FFFF, 46'd4, 1'b0, 1'b0, NORMAL_LAT};
        vecs[4]  = '{76'd100, 46'd10, 32'd10, 46'd0, 1'b0, 1'b0, NORMAL_LAT};
        vecs[5]  = '{76'd0, 46'd1, 32'd0, 46'd0, 1'b0, 1'b0, NORMAL_LAT};
        vecs[6]  = '{76'hFFFF_FFFF, 46'd1, 32'hFFFF_FFFF, 46'd0, 1'b0, 1'b0, NORMAL_LAT};
        vecs[7]  = '{76'h1_0000_0000, 46'd1, 32'hFFFF_FFFF, 46'd0, 1'b0, 1'b1, SPECIAL_LAT};
        vecs[8]  = '{76'd0, 46'd0, 32'hFFFF_FFFF, 46'd0, 1'b1, 1'b0, SPECIAL_LAT};
        vecs[9]  = '{76'h8_0000_0001, 46'd9, 32'hE38E_38E3, 46'd6, 1'b0, 1'b0, NORMAL_LAT};
        vecs[10] = '{76'hFFF_FFFF_FFFF_FFFF_FFFF, 46'h3FFF_FFFF_FFFF, 32'h4000_0000,
                     46'h3FFF_FFFF, 1'b0, 1'b0, NORMAL_LAT};

        bus.ce        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        #3;
        checkResult("reset", '0, '0, 1'b0, 1'b0);
        checkOutput("reset in_ready", 128'(bus.in_ready), 128'(1));
        checkOutput("reset out_valid", 128'(bus.out_valid), 128'(0));
        step();
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < NUM_VECS; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // ce low for 5 cycles mid-ITER, then again while the result waits in DONE.
        applyStimulus(76'd1000, 46'd7);
        repeat (8) step();
        bus.ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("stall%0d in_ready", k), 128'(bus.in_ready), 128'(0));
            checkOutput($sformatf("stall%0d out_valid", k), 128'(bus.out_valid), 128'(0));
        end
        bus.ce = 1'b1;
        waitResult(lat);
        checkOutput("stall latency", 128'(lat), 128'(NORMAL_LAT + 5));
        checkResult("stall", 32'd142, 46'd6, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        bus.ce        = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("done-freeze%0d out_valid", k), 128'(bus.out_valid), 128'(1));
        end
        bus.ce = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checkOutput("done-freeze release out_valid", 128'(bus.out_valid), 128'(0));
        checkOutput("done-freeze release in_ready", 128'(bus.in_ready), 128'(1));
        checkOutput("dout kept after accept", 128'(bus.dout), 128'(142));

        // Reset mid-ITER abandons the operation and clears outputs asynchronously.
        applyStimulus(76'd1000, 46'd7);
        repeat (10) step();
        reset_n = 1'b0;
        #1;
        checkResult("midreset", '0, '0, 1'b0, 1'b0);
        checkOutput("midreset in_ready", 128'(bus.in_ready), 128'(1));
        checkOutput("midreset out_valid", 128'(bus.out_valid), 128'(0));
        step();
        reset_n = 1'b1;
        step();
        runVector("post-reset", vecs[4]);

        // Result held for 10 cycles with out_ready low must not move.
        applyStimulus(vecs[9].din0, vecs[9].din1);
        waitResult(lat);
        checkOutput("hold latency", 128'(lat), 128'(NORMAL_LAT));
        for (int k = 0; k < 10; k++) begin
            step();
            checkOutput($sformatf("hold%0d out_valid", k), 128'(bus.out_valid), 128'(1));
            checkResult($sformatf("hold%0d", k), vecs[9].expDout, vecs[9].expRem, 1'b0, 1'b0);
        end
        releaseResult("hold");

        for (int n = 0; n < NUM_RANDOM; n++) begin
            mode = $urandom_range(0, 9);
            a    = $urandom();
            if (mode <= 3) begin
                v.din1 = {2'b00, 44'({$urandom(), $urandom()})} >> $urandom_range(0, 43);
                if (v.din1 == '0) v.din1 = 46'd1;
                v.din0 = W0'(a) * W0'(v.din1);
            end else if (mode <= 6) begin
                v.din0 = W0'({$urandom(), $urandom(), $urandom()});
                v.din1 = W1'({$urandom(), $urandom()}) >> $urandom_range(0, 45);
            end else if (mode == 7) begin
                v.din0 = W0'({$urandom(), $urandom(), $urandom()}) >> $urandom_range(0, 75);
                v.din1 = W1'($urandom_range(1, 65535));
            end else if (mode == 8) begin
                v.din0 = W0'({$urandom(), $urandom(), $urandom()});
                v.din1 = '0;
            end else begin
                v.din0 = W0'({$urandom(), $urandom(), $urandom()});
                v.din1 = W1'(v.din0 >> WQ) + W1'($urandom_range(0, 1));
            end
            modelDivide(v.din0, v.din1, v.expDout, v.expRem, v.expDbz, v.expOvf, v.expLat);

            applyStimulus(v.din0, v.din1);
            waitResult(lat);
            checkOutput($sformatf("rnd%0d latency", n), 128'(lat), 128'(v.expLat));
            checkResult($sformatf("rnd%0d", n), v.expDout, v.expRem, v.expDbz, v.expOvf);
            if (mode <= 3) begin
                checkOutput($sformatf("rnd%0d product dout", n), 128'(bus.dout), 128'(a));
                checkOutput($sformatf("rnd%0d product rem", n), 128'(bus.rem), 128'(0));
            end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                step();
                checkOutput($sformatf("rnd%0d held dout", n), 128'(bus.dout), 128'(v.expDout));
            end
            releaseResult($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
